imem_line_responder: RTL and testbench

//   Instruction-memory responder on the fetch side of the compute unit.

---
 rtl/imem_line_responder.sv | 160 ++++++++++++++++
 tb/tb_imem_line_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_line_responder.sv
// Instruction-memory line responder for the fetch unit.
// A small direct-mapped line buffer answers word fetches one cycle after the
// address is sampled. On a miss it stalls the fetch unit and refills the whole
// line from the external memory read port, beats arriving in ascending word order.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_en         sample req_addr on this edge (ignored while imem_stall)
//   req_addr       fetch byte address, bits [1:0] ignored
//   inst_rdata     word for the sampled address, 0 when not a hit
//   inst_hit       inst_rdata valid this cycle
//   imem_stall     miss/refill in progress, fetch must hold
//   flush          invalidate all lines (single-cycle pulse)
//   mem_req_valid  refill request valid
//   mem_req_ready  fabric accepts the refill request
//   mem_req_addr   line-aligned refill byte address
//   mem_rsp_valid  refill beat valid
//   mem_rsp_data   refill beat data
module imem_line_responder #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_en,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_hit,
    output logic              imem_stall,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data
);

    localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned TAG_W   = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int unsigned LSB_IDX = 2 + OFF_W;
    localparam int unsigned LSB_TAG = 2 + OFF_W + IDX_W;
    localparam int unsigned WORDS   = LINES * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [ADDR_W-1:0]   addr_q;
    logic                sampled_q;
    logic                flush_pend;
    logic [LINES-1:0]    valid_q;
    logic [OFF_W-1:0]    beat_cnt;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [31:0]         data_mem [WORDS];

    logic [IDX_W-1:0]    look_idx;
    logic [OFF_W-1:0]    look_off;
    logic [TAG_W-1:0]    look_tag;
    logic                hit;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                fill_beat;
    logic                last_beat;

    // Lookup fields come from the staged address; refill fields from the
    // request address, which stays fixed for the whole refill.
    assign look_idx  = addr_q[LSB_IDX +: IDX_W];
    assign look_off  = addr_q[2 +: OFF_W];
    assign look_tag  = addr_q[LSB_TAG +: TAG_W];
    assign fill_idx  = mem_req_addr[LSB_IDX +: IDX_W];
    assign fill_tag  = mem_req_addr[LSB_TAG +: TAG_W];
    assign fill_beat = (state == S_FILL) && mem_rsp_valid;
    assign last_beat = fill_beat && (beat_cnt == OFF_W'(WORDS_PER_LINE - 1));

    assign hit = sampled_q && valid_q[look_idx] &&
                 (tag_mem[look_idx] == look_tag) && (state == S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (sampled_q && !hit) state_next = S_REQ;
            S_REQ:  if (mem_req_ready)     state_next = S_FILL;
            S_FILL: if (last_beat)         state_next = S_IDLE;
            default:                       state_next = S_IDLE;
        endcase
    end

    // Output logic; lookup results are visible in the cycle after sampling.
    always_comb begin
        mem_req_valid = 1'b0;
        inst_hit      = hit;
        imem_stall    = sampled_q && !hit;
        inst_rdata    = '0;
        if (state == S_REQ) mem_req_valid = 1'b1;
        if (hit) inst_rdata = data_mem[{look_idx, look_off}];
    end

    // Request staging, refill bookkeeping and line valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            sampled_q    <= 1'b0;
            flush_pend   <= 1'b0;
            valid_q      <= '0;
            beat_cnt     <= '0;
            mem_req_addr <= '0;
        end else begin
            if (req_en && !imem_stall) begin
                addr_q    <= req_addr;
                sampled_q <= 1'b1;
            end
            if ((state == S_IDLE) && (state_next == S_REQ)) begin
                mem_req_addr <= {addr_q[ADDR_W-1:LSB_IDX], {LSB_IDX{1'b0}}};
            end
            if ((state == S_REQ) && mem_req_ready) begin
                beat_cnt <= '0;
            end else if (fill_beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            // A flush during a refill lets the refill finish but keeps the
            // resulting line invalid, since its contents may predate the flush.
            if (flush) begin
                valid_q <= '0;
                if (state != S_IDLE) flush_pend <= 1'b1;
            end
            if (last_beat) begin
                valid_q[fill_idx] <= !flush_pend && !flush;
                flush_pend        <= 1'b0;
            end
        end
    end

    // Line storage; contents are only meaningful under a valid bit.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_mem[{fill_idx, beat_cnt}] <= mem_rsp_data;
        end
        if (last_beat) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_imem_line_responder.sv
// Testbench for imem_line_responder: directed fetch/refill sequences with a
// scoreboard queue of expected instruction words, popped by a monitor on the
// first hit after each accepted request.
module tb_imem_line_responder;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_en;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       inst_rdata;
    logic              inst_hit;
    logic              imem_stall;
    logic              flush;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit pending = 1'b0;

    imem_line_responder #(
        .ADDR_W(ADDR_W),
        .LINES(16),
        .WORDS_PER_LINE(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_en(req_en),
        .req_addr(req_addr),
        .inst_rdata(inst_rdata),
        .inst_hit(inst_hit),
        .imem_stall(imem_stall),
        .flush(flush),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare the first hit after each accepted request.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            if (pending && inst_hit) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata: hit with empty scoreboard, got 0x%08h", inst_rdata);
                end else begin
                    check("rdata", inst_rdata, exp_q.pop_front());
                end
                pending = 1'b0;
            end
            if (req_en && !imem_stall) pending = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] e, input bit push);
        check("accept_no_stall", 32'(imem_stall), 32'd0);
        req_en   = 1'b1;
        req_addr = a;
        if (push) exp_q.push_back(e);
        tick();
        req_en   = 1'b0;
    endtask

    // Fabric model: accept the request after ready_delay cycles and return
    // four beats base+0..base+3; flush pulses with beat flush_beat (-1: none).
    task automatic serve_line(input logic [31:0] exp_addr, input logic [31:0] base,
                              input int ready_delay, input int flush_beat);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("mem_req_valid_seen", 32'(mem_req_valid), 32'd1);
        if (!mem_req_valid) return;
        check("mem_req_addr", mem_req_addr, exp_addr);
        for (int i = 0; i < ready_delay; i++) begin
            mem_req_ready = 1'b0;
            tick();
            check("hold_req_valid", 32'(mem_req_valid), 32'd1);
            check("hold_req_addr", mem_req_addr, exp_addr);
            check("hold_stall", 32'(imem_stall), 32'd1);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = base + 32'(b);
            flush         = (b == flush_beat);
            tick();
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        flush         = 1'b0;
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        req_en        = 1'b0;
        req_addr      = '0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        #1;
        check("rst_hit", 32'(inst_hit), 32'd0);
        check("rst_stall", 32'(imem_stall), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_req_addr", mem_req_addr, 32'd0);
        check("rst_rdata", inst_rdata, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Cold miss on line 0, refill A0..A3.
        issue(32'h0, 32'hA0, 1'b1);
        check("cold_stall", 32'(imem_stall), 32'd1);
        check("cold_hit", 32'(inst_hit), 32'd0);
        serve_line(32'h0, 32'hA0, 0, -1);
        check("cold_done_stall", 32'(imem_stall), 32'd0);
        check("cold_done_hit", 32'(inst_hit), 32'd1);

        // Back-to-back hits in the same line.
        issue(32'h4, 32'hA1, 1'b1);
        check("b2b_stall", 32'(imem_stall), 32'd0);
        check("b2b_req_valid", 32'(mem_req_valid), 32'd0);
        issue(32'h8, 32'hA2, 1'b1);
        check("b2b_stall", 32'(imem_stall), 32'd0);
        check("b2b_req_valid", 32'(mem_req_valid), 32'd0);
        issue(32'hC, 32'hA3, 1'b1);
        check("b2b_stall", 32'(imem_stall), 32'd0);
        check("b2b_req_valid", 32'(mem_req_valid), 32'd0);
        tick();

        // Conflict on index 0 evicts line 0.
        issue(32'h100, 32'hB0, 1'b1);
        check("conf_stall", 32'(imem_stall), 32'd1);
        serve_line(32'h100, 32'hB0, 0, -1);
        check("conf_done_hit", 32'(inst_hit), 32'd1);
        tick();
        issue(32'h0, 32'hA0, 1'b1);
        check("evict_stall", 32'(imem_stall), 32'd1);
        serve_line(32'h0, 32'hA0, 5, -1);
        check("evict_done_hit", 32'(inst_hit), 32'd1);
        tick();

        // Flush during beat 2: line lands invalid, exactly one re-request.
        issue(32'h200, 32'hC0, 1'b1);
        serve_line(32'h200, 32'hC0, 0, 2);
        check("flush_remiss_stall", 32'(imem_stall), 32'd1);
        check("flush_remiss_hit", 32'(inst_hit), 32'd0);
        serve_line(32'h200, 32'hC0, 0, -1);
        check("flush_done_hit", 32'(inst_hit), 32'd1);
        repeat (2) tick();
        check("flush_no_third_req", 32'(mem_req_valid), 32'd0);
        check("flush_idle_stall", 32'(imem_stall), 32'd0);

        // Reset in the middle of a refill, then stray beats.
        issue(32'h300, 32'h0, 1'b0);
        n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("rf_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hEE00 + 32'(b);
            tick();
        end
        mem_rsp_data = 32'hEEFF;
        rst_n = 1'b0;
        #1;
        check("mrst_hit", 32'(inst_hit), 32'd0);
        check("mrst_stall", 32'(imem_stall), 32'd0);
        check("mrst_req_valid", 32'(mem_req_valid), 32'd0);
        check("mrst_req_addr", mem_req_addr, 32'd0);
        check("mrst_rdata", inst_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("stray_req_valid", 32'(mem_req_valid), 32'd0);
        check("stray_stall", 32'(imem_stall), 32'd0);
        check("stray_hit", 32'(inst_hit), 32'd0);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        tick();

        // The partial line must be invalid: the same address misses and refills.
        issue(32'h300, 32'hD0, 1'b1);
        check("post_rst_stall", 32'(imem_stall), 32'd1);
        serve_line(32'h300, 32'hD0, 0, -1);
        check("post_rst_hit", 32'(inst_hit), 32'd1);
        repeat (3) tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("no_pending", 32'(pending), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
